// File: rtl/switch_debounce_pkg.sv
// Shared constants and types for the switch debounce block.
// Board clock and debounce window set the default settle time.
package switch_debounce_pkg;

  localparam int CLK_HZ      = 16_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES =
    CLK_HZ / 1000 * DEBOUNCE_MS;

  typedef struct packed {
    logic state;
    logic press;
    logic rel;
    logic toggle;
  } chan_out_t;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch pins in, conditioned switch levels and pulses out.
// master = consumer/board side, slave = debounce block.
interface switch_debounce_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] SW_IN;
  logic [WIDTH-1:0] SW_STATE;
  logic [WIDTH-1:0] SW_PRESS;
  logic [WIDTH-1:0] SW_RELEASE;
  logic [WIDTH-1:0] SW_TOGGLE;

  modport master (
    output SW_IN,
    input  SW_STATE,
    input  SW_PRESS,
    input  SW_RELEASE,
    input  SW_TOGGLE
  );

  modport slave (
    input  SW_IN,
    output SW_STATE,
    output SW_PRESS,
    output SW_RELEASE,
    output SW_TOGGLE
  );

endinterface

// File: rtl/switch_debounce_chan.sv
// One switch channel: 2-flop sync, settle counter, level,
// press/release pulses and press-toggled latch.
module debounce_chan
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 18
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      sw_n,
  output chan_out_t out
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             state;
  logic             press;
  logic             rel;
  logic             toggle;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      state  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      toggle <= 1'b0;
    end else begin
      s1     <= sw_n;
      s2     <= s1;
      press  <= 1'b0;
      rel    <= 1'b0;
      toggle <= toggle ^ press;
      // any return to the held level restarts the window
      if (s2 == state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        state <= s2;
        press <= s2;
        rel   <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign out.state  = state;
  assign out.press  = press;
  assign out.rel    = rel;
  assign out.toggle = toggle;

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH raw switch pins into clean levels,
// edge pulses and toggle latches, normalised so 1 = pressed.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 18,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  switch_debounce_if.slave   sw
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be >= 2");
  end

  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  logic [WIDTH-1:0] sw_n;
  chan_out_t        chan [WIDTH];

  assign sw_n = sw.SW_IN ^ {WIDTH{ACTIVE_LOW}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .CLK  (CLK),
      .RST  (RST),
      .sw_n (sw_n[i]),
      .out  (chan[i])
    );

    assign sw.SW_STATE[i]   = chan[i].state;
    assign sw.SW_PRESS[i]   = chan[i].press;
    assign sw.SW_RELEASE[i] = chan[i].rel;
    assign sw.SW_TOGGLE[i]  = chan[i].toggle;
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever a pulse appears.
module tb_switch_debounce;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] state;
    logic [3:0] tog;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t       sb [$];
  bit         tog_pend = 1'b0;
  logic [3:0] tog_exp;

  switch_debounce_if #(.WIDTH(4)) sw_if ();

  switch_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .sw  (sw_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int at,
                           input logic [3:0] p,
                           input logic [3:0] r,
                           input logic [3:0] s,
                           input logic [3:0] t);
    exp_t e;
    e.cyc   = at;
    e.press = p;
    e.rel   = r;
    e.state = s;
    e.tog   = t;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] outs();
    return {sw_if.SW_STATE, sw_if.SW_PRESS,
            sw_if.SW_RELEASE, sw_if.SW_TOGGLE};
  endfunction

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (tog_pend) begin
      tog_pend = 1'b0;
      chk("toggle_after_pulse", 32'(sw_if.SW_TOGGLE),
          32'(tog_exp));
    end
    if (cyc > 0 &&
        (sw_if.SW_PRESS | sw_if.SW_RELEASE) !== 4'h0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse at cycle %0d: press %h release %h expected none",
                 cyc, sw_if.SW_PRESS, sw_if.SW_RELEASE);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("press", 32'(sw_if.SW_PRESS), 32'(e.press));
        chk("release", 32'(sw_if.SW_RELEASE), 32'(e.rel));
        chk("state", 32'(sw_if.SW_STATE), 32'(e.state));
        tog_pend = 1'b1;
        tog_exp  = e.tog;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    sw_if.SW_IN = 4'hF;
    rst = 1'b1;

    // 1: reset with all switches released
    tick(1);
    chk("reset_outs_1", 32'(outs()), 32'h0);
    tick(1);
    chk("reset_outs_2", 32'(outs()), 32'h0);
    tick(1);
    chk("reset_outs_3", 32'(outs()), 32'h0);
    rst = 1'b0;
    tick(20);
    chk("idle_outs", 32'(outs()), 32'h0);

    // 2: clean press on SW1
    sw_if.SW_IN[0] = 1'b0;
    expect_ev(cyc + 10, 4'h1, 4'h0, 4'h1, 4'h1);
    tick(14);

    // 3: bounce on SW2 then settle low
    sw_if.SW_IN[1] = 1'b0;
    tick(5);
    sw_if.SW_IN[1] = 1'b1;
    tick(2);
    sw_if.SW_IN[1] = 1'b0;
    expect_ev(cyc + 10, 4'h2, 4'h0, 4'h3, 4'h3);
    tick(14);
    chk("bounce_state", 32'(sw_if.SW_STATE), 32'h3);

    // 4: release SW1 then press again
    sw_if.SW_IN[0] = 1'b1;
    expect_ev(cyc + 10, 4'h0, 4'h1, 4'h2, 4'h3);
    tick(14);
    sw_if.SW_IN[0] = 1'b0;
    expect_ev(cyc + 10, 4'h1, 4'h0, 4'h3, 4'h2);
    tick(14);

    // 5: release all, then all pressed in one cycle
    sw_if.SW_IN = 4'hF;
    expect_ev(cyc + 10, 4'h0, 4'h3, 4'h0, 4'h2);
    tick(14);
    sw_if.SW_IN = 4'h0;
    expect_ev(cyc + 10, 4'hF, 4'h0, 4'hF, 4'hD);
    tick(14);
    sw_if.SW_IN = 4'hF;
    expect_ev(cyc + 10, 4'h0, 4'hF, 4'h0, 4'hD);
    tick(14);
    chk("all_released", 32'(sw_if.SW_STATE), 32'h0);

    // 6: reset in the middle of a count on SW3
    sw_if.SW_IN[2] = 1'b0;
    tick(7);
    rst = 1'b1;
    tick(1);
    chk("midreset_outs", 32'(outs()), 32'h0);
    rst = 1'b0;
    c = cyc;
    expect_ev(c + 10, 4'h4, 4'h0, 4'h4, 4'h4);
    tick(9);
    chk("midreset_state_pre", 32'(sw_if.SW_STATE), 32'h0);
    tick(5);
    chk("midreset_state_post", 32'(sw_if.SW_STATE), 32'h4);

    tick(2);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
